arith_seq_ctrl: RTL and testbench

//  - Sequences the shared 16-bit arithmetic unit to execute 32-bit add/sub ops as two chained halves, low half then high.
//  - Arbitrates the unit between two requesters, round-robin; one op in flight at a time.
//  - Sits between requesters (valid/ready) and the arithmetic unit; returns result plus carry/overflow flags.

---
 rtl/arith_pkg.sv | 30 +++
 rtl/rr_arbiter_2.sv | 29 ++
 rtl/arith_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_arith_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - op encodings, ALU codes and sequencer states for arith_seq_ctrl
package arith_pkg;

    localparam logic [1:0] OP_SADD = 2'b00;
    localparam logic [1:0] OP_UADD = 2'b01;
    localparam logic [1:0] OP_SSUB = 2'b10;
    localparam logic [1:0] OP_USUB = 2'b11;

    localparam logic [2:0] ALU_SADD = 3'b000;
    localparam logic [2:0] ALU_UADD = 3'b001;
    localparam logic [2:0] ALU_SSUB = 3'b010;
    localparam logic [2:0] ALU_USUB = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_RESP = 2'b11
    } state_e;

    function automatic logic op_is_sub(input logic [1:0] op);
        return op[1];
    endfunction

    // Low half always runs unsigned so the carry chains cleanly into the high half.
    function automatic logic [2:0] lo_code(input logic [1:0] op);
        return op_is_sub(op) ? ALU_USUB : ALU_UADD;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant; pointer moves past the winner on accept
module rr_arbiter_2 #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic prio_q;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= RR_INIT;
        end else if (accept_i && (grant_o != 2'b00)) begin
            prio_q <= grant_o[0];
        end
    end

endmodule

// File: rtl/arith_seq_ctrl.sv
// rtl/arith_seq_ctrl.sv - runs 32-bit add/sub as two chained passes of a shared 16-bit ALU
module arith_seq_ctrl
    import arith_pkg::*;
#(
    parameter int HALF_W  = 16,
    parameter int RR_INIT = 0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [1:0]            req0_op,
    input  logic [2*HALF_W-1:0]   req0_a,
    input  logic [2*HALF_W-1:0]   req0_b,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [1:0]            req1_op,
    input  logic [2*HALF_W-1:0]   req1_a,
    input  logic [2*HALF_W-1:0]   req1_b,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [2*HALF_W-1:0]   resp_result,
    output logic                  resp_carry,
    output logic                  resp_ovf,

    output logic [HALF_W-1:0]     alu_a,
    output logic [HALF_W-1:0]     alu_b,
    output logic [2:0]            alu_code,
    output logic                  alu_cin,
    output logic                  alu_coe,
    input  logic [HALF_W-1:0]     alu_c,
    input  logic                  alu_cout,
    input  logic                  alu_vout
);

    state_e                state_q;
    logic [1:0]            op_q;
    logic                  id_q;
    logic [HALF_W-1:0]     a_hi_q;
    logic [HALF_W-1:0]     b_hi_q;
    logic [HALF_W-1:0]     lo_q;

    logic [HALF_W-1:0]     alu_a_q;
    logic [HALF_W-1:0]     alu_b_q;
    logic [2:0]            alu_code_q;
    logic                  alu_cin_q;

    logic                  resp_valid_q;
    logic                  resp_id_q;
    logic [2*HALF_W-1:0]   resp_result_q;
    logic                  resp_carry_q;
    logic                  resp_ovf_q;

    logic [1:0]            grant;
    logic                  accept;
    logic                  win_id;
    logic [1:0]            win_op;
    logic [2*HALF_W-1:0]   win_a;
    logic [2*HALF_W-1:0]   win_b;

    rr_arbiter_2 #(
        .RR_INIT (RR_INIT != 0)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({req1_valid, req0_valid}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    assign accept     = (state_q == S_IDLE) && !reset && (grant != 2'b00);
    assign req0_ready = accept && grant[0];
    assign req1_ready = accept && grant[1];

    assign win_id = grant[1];
    assign win_op = win_id ? req1_op : req0_op;
    assign win_a  = win_id ? req1_a  : req0_a;
    assign win_b  = win_id ? req1_b  : req0_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= OP_SADD;
            id_q          <= 1'b0;
            a_hi_q        <= '0;
            b_hi_q        <= '0;
            lo_q          <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_code_q    <= ALU_UADD;
            alu_cin_q     <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_carry_q  <= 1'b0;
            resp_ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        id_q       <= win_id;
                        op_q       <= win_op;
                        a_hi_q     <= win_a[2*HALF_W-1:HALF_W];
                        b_hi_q     <= win_b[2*HALF_W-1:HALF_W];
                        alu_a_q    <= win_a[HALF_W-1:0];
                        alu_b_q    <= win_b[HALF_W-1:0];
                        alu_code_q <= lo_code(win_op);
                        alu_cin_q  <= op_is_sub(win_op);
                        state_q    <= S_LO;
                    end
                end
                S_LO: begin
                    // alu_cin_q doubles as the low-half carry feeding the high pass.
                    lo_q       <= alu_c;
                    alu_a_q    <= a_hi_q;
                    alu_b_q    <= b_hi_q;
                    alu_code_q <= {1'b0, op_q};
                    alu_cin_q  <= alu_cout;
                    state_q    <= S_HI;
                end
                S_HI: begin
                    resp_result_q <= {alu_c, lo_q};
                    resp_id_q     <= id_q;
                    resp_carry_q  <= op_q[0] ? alu_cout : 1'b0;
                    case (op_q)
                        OP_SADD: resp_ovf_q <= alu_vout;
                        OP_SSUB: resp_ovf_q <= alu_cout;
                        default: resp_ovf_q <= 1'b0;
                    endcase
                    resp_valid_q  <= 1'b1;
                    state_q       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_code    = alu_code_q;
    assign alu_cin     = alu_cin_q;
    assign alu_coe     = 1'b0;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_carry  = resp_carry_q;
    assign resp_ovf    = resp_ovf_q;

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// tb/tb_arith_seq_ctrl.sv - directed bench for arith_seq_ctrl with a behavioural 16-bit ALU
module tb_arith_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, resp_carry, resp_ovf;
    logic [31:0] resp_result;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_code;
    logic        alu_cin, alu_coe, alu_cout, alu_vout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arith_seq_ctrl #(.HALF_W(16), .RR_INIT(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_carry(resp_carry), .resp_ovf(resp_ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_cin(alu_cin),
        .alu_coe(alu_coe), .alu_c(alu_c), .alu_cout(alu_cout), .alu_vout(alu_vout)
    );

    // Behavioural arithmetic unit: subtract is a + ~b + cin.
    logic [15:0] bb;
    logic [16:0] sum;
    logic        sov;
    always_comb begin
        bb       = alu_code[1] ? ~alu_b : alu_b;
        sum      = {1'b0, alu_a} + {1'b0, bb} + {16'd0, alu_cin};
        alu_c    = sum[15:0];
        sov      = (alu_a[15] == bb[15]) && (sum[15] != alu_a[15]);
        alu_vout = sov;
        alu_cout = (alu_code == 3'b010) ? sov : sum[16];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        chk("grant_ready", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (resp_valid) break;
        end
    endtask

    task automatic run_op(input string tag, input logic id, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input logic ev);
        int n;
        issue(id, op, a, b);
        wait_resp(n);
        chk({tag, "_latency"}, n, 32'd3);
        chk({tag, "_result"}, resp_result, er);
        chk({tag, "_carry"}, {31'd0, resp_carry}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, resp_ovf}, {31'd0, ev});
        chk({tag, "_id"}, {31'd0, resp_id}, {31'd0, id});
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int got;
        int ids[4];
        logic [31:0] res[4];

        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
        req0_op = 2'b01; req1_op = 2'b01;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Reset values, with both requesters pushing
        repeat (2) @(negedge clk);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_alu_code", {29'd0, alu_code}, 32'd1);
        chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
        chk("rst_alu_cin", {30'd0, alu_cin, alu_coe}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;

        // Round robin with both valid continuously
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'd5;  req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'd10; req1_b = 32'd4;
        resp_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 60 && got < 4; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ids[got] = resp_id;
                res[got] = resp_result;
                got++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("rr_count", got, 32'd4);
        for (int i = 0; i < got; i++) begin
            chk("rr_id", ids[i], i % 2);
            chk("rr_result", res[i], (i % 2) ? 32'd6 : 32'd8);
        end

        // Directed arithmetic vectors
        run_op("uadd_lo_carry", 1'b0, 2'b01, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0);
        run_op("uadd_wrap",     1'b0, 2'b01, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        run_op("usub_borrow",   1'b0, 2'b11, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("ssub_ovf",      1'b1, 2'b10, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
        run_op("sadd_ovf",      1'b0, 2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
        run_op("sadd_plain",    1'b1, 2'b00, 32'h00000010, 32'hFFFFFFFF, 32'h0000000F, 1'b0, 1'b0);

        // Back-pressure hold for 5 cycles
        issue(1'b0, 2'b01, 32'h12345678, 32'h11111111);
        wait_resp(n);
        chk("bp_latency", n, 32'd3);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_result", resp_result, 32'h23456789);
            chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("bp_release", {31'd0, resp_valid}, 32'd0);

        // Reset in HI discards the op; priority returns to requester 0
        issue(1'b0, 2'b01, 32'd1, 32'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("hi_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("hi_rst_alu_code", {29'd0, alu_code}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("hi_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(n);
        chk("post_rst_latency", n, 32'd3);
        chk("post_rst_id", {31'd0, resp_id}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
